// File: rtl/axi_pwm_lite_responder_if.sv
// AXI4-Lite bus bundle between a master and the PWM register responder.
// The master modport drives address/data/valid; the slave modport returns readies, responses and read data.
interface axi_pwm_lite_responder_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_pwm_lite_responder.sv
// AXI4-Lite 4-register PWM bank (CTRL/PERIOD/DUTY/PRESCALE) driving a glitch-free PWM generator; PWM_IRQ_EN adds irq_o.
// Latency: write accepted 1 cycle after AW+W valid, bvalid next cycle; rvalid 1 cycle after AR handshake; pwm_o registered.
// Backpressure: one write and one read outstanding; bvalid/rvalid held until bready/rready, no new accept meanwhile.
module axi_pwm_lite_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    axi_pwm_lite_responder_if.slave s00_axi,
    output logic                    pwm_o
`ifdef PWM_IRQ_EN
    ,
    output logic                    irq_o
`endif
);
    localparam int DW = C_S_AXI_DATA_WIDTH;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic          awready_q, awready_d;
    logic          bvalid_q, bvalid_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] regs_q [4];
    logic [DW-1:0] regs_d [4];

    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
    logic [1:0]                    wsel, rsel;
    logic                          unused_ok;

    assign awaddr    = s00_axi.awaddr;
    assign araddr    = s00_axi.araddr;
    assign wsel      = awaddr[3:2];
    assign rsel      = araddr[3:2];
    assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, awaddr[1:0], araddr[1:0]};

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = awready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = 2'b00;

    // AW and W are only ever accepted together; the ready pulse lasts one cycle.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = 1'b0;
        bvalid_d  = bvalid_q;
        regs_d    = regs_q;
        case (w_state_q)
            W_IDLE: begin
                if (awready_q && s00_axi.awvalid && s00_axi.wvalid) begin
                    for (int b = 0; b < DW / 8; b++) begin
                        if (s00_axi.wstrb[b]) begin
                            regs_d[wsel][8*b +: 8] = s00_axi.wdata[8*b +: 8];
                        end
                    end
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end else if (!awready_q && s00_axi.awvalid && s00_axi.wvalid) begin
                    awready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (s00_axi.bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // rdata samples regs_q, so a same-cycle write is not yet visible.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (arready_q && s00_axi.arvalid) begin
                    rdata_d   = regs_q[rsel];
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end else if (!arready_q && s00_axi.arvalid) begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (s00_axi.rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    logic                 en, inv, run, tick, wrap, load;
    logic                 en_prev_q, en_prev_d;
    logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d, cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] period_s_q, period_s_d, duty_s_q, duty_s_d, prescale_s_q, prescale_s_d;
    logic                 pwm_q, pwm_d;

    assign en        = regs_q[0][0];
    assign inv       = regs_q[0][1];
    assign en_prev_d = en;
    // Counting starts the cycle after EN rises, once the shadows hold the new settings.
    assign run       = en & en_prev_q;
    assign tick      = (pcnt_q == prescale_s_q);
    assign wrap      = tick && (cnt_q == period_s_q);
    assign load      = (en && !en_prev_q) || (run && wrap);

    always_comb begin
        period_s_d   = period_s_q;
        duty_s_d     = duty_s_q;
        prescale_s_d = prescale_s_q;
        pcnt_d       = '0;
        cnt_d        = '0;
        if (load) begin
            period_s_d   = regs_q[1][CNT_WIDTH-1:0];
            duty_s_d     = regs_q[2][CNT_WIDTH-1:0];
            prescale_s_d = regs_q[3][CNT_WIDTH-1:0];
        end
        if (run) begin
            pcnt_d = tick ? '0 : pcnt_q + CNT_WIDTH'(1);
            if (tick) begin
                cnt_d = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
        pwm_d = (run && (cnt_q < duty_s_q)) ^ inv;
    end

    assign pwm_o = pwm_q;

`ifdef PWM_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = run && regs_q[0][2] && wrap;
    assign irq_o = irq_q;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
`endif

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            awready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            regs_q       <= '{default: '0};
            en_prev_q    <= 1'b0;
            pcnt_q       <= '0;
            cnt_q        <= '0;
            period_s_q   <= '0;
            duty_s_q     <= '0;
            prescale_s_q <= '0;
            pwm_q        <= 1'b0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            awready_q    <= awready_d;
            bvalid_q     <= bvalid_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            regs_q       <= regs_d;
            en_prev_q    <= en_prev_d;
            pcnt_q       <= pcnt_d;
            cnt_q        <= cnt_d;
            period_s_q   <= period_s_d;
            duty_s_q     <= duty_s_d;
            prescale_s_q <= prescale_s_d;
            pwm_q        <= pwm_d;
        end
    end
endmodule

// File: doc/axi_pwm_lite_responder.md
Name: axi_pwm_lite_responder

Overview:
AXI4-Lite slave (responder) holding a 4-register PWM control bank, plus the PWM generator those registers drive. It is the target end of the AXI4-Lite master VIP sequences used in the PWM bench, and is instantiated in the block design behind the PS AXI interconnect. The bank is byte-strobed, and any register written reads back the same value. Period and duty take effect only at a period boundary, so the output never glitches.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, AXI address width; address bits [3:2] select the register.
CNT_WIDTH, 32, width of the period counter and the prescale counter.

Ports:
s00_axi_aclk  in  1  single clock.
s00_axi_aresetn  in  1  asynchronous active-low reset.
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
s00_axi_awprot  in  3  ignored.
s00_axi_awvalid/s00_axi_awready  in/out  1  write address handshake.
s00_axi_wdata  in  32  write data.
s00_axi_wstrb  in  4  byte enables.
s00_axi_wvalid/s00_axi_wready  in/out  1  write data handshake.
s00_axi_bresp  out  2  write response; always 2'b00.
s00_axi_bvalid/s00_axi_bready  out/in  1  write response handshake.
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
s00_axi_arprot  in  3  ignored.
s00_axi_arvalid/s00_axi_arready  in/out  1  read address handshake.
s00_axi_rdata  out  32  read data.
s00_axi_rresp  out  2  read response; always 2'b00.
s00_axi_rvalid/s00_axi_rready  out/in  1  read data handshake.
pwm_o  out  1  PWM output.

Behaviour:
- Clock and reset: one clock, s00_axi_aclk. Reset s00_axi_aresetn is asynchronous and active-low. Release is taken synchronously.
- Reset values: all readies, valids, resp, rdata, pwm_o, registers, shadows and counters = 0.
- Register map:
  - 0x0 CTRL: bit0 EN, bit1 INV, bit2 IRQ_EN; all 32 bits are stored.
  - 0x4 PERIOD.
  - 0x8 DUTY.
  - 0xC PRESCALE.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: assert awready and wready together for one cycle only when awvalid && wvalid; this is the AW/W join, with no independent acceptance.
  - On the accept cycle, each byte lane with wstrb=1 of the reg selected by awaddr[3:2] is updated. The register is written on the clock edge after the handshake.
  - After the accept cycle: bvalid=1, go to W_RESP.
  - W_RESP: hold bvalid until bready, then return to W_IDLE. At most one write is outstanding.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1 for one cycle when arvalid. Latch rdata from the reg at araddr[3:2]; rvalid=1 the next cycle. Latency from AR handshake to rvalid is 1 cycle.
  - R_DATA: hold rdata/rvalid stable until rready, then return to R_IDLE.
- Read and write channels are independent and may complete in the same cycle.
- A read of a register being written in the same cycle returns the old value.
- Shadows: PERIOD_S, DUTY_S and PRESCALE_S load from the registers on:
  - EN rising, or
  - the tick that wraps the period counter.
- Prescaler: pcnt counts 0..PRESCALE_S. tick=1 when pcnt==PRESCALE_S; pcnt then wraps to 0. PRESCALE=0 gives tick every cycle.
- Period counter: cnt advances on tick and wraps to 0 after reaching PERIOD_S.
- Output: pwm_o registered = EN & (cnt < DUTY_S), XORed with INV.
  - DUTY_S >= PERIOD_S+1: constant active level.
  - DUTY_S = 0: constant inactive level.
  - PERIOD_S = 0: cnt stays 0.
- EN=0: pcnt and cnt are held at 0, pwm_o=INV. Clearing EN mid-period takes effect on the next cycle.
- Reset asserted mid-transaction: both FSMs return to idle immediately and all valids drop. The master must reissue.

Optional Feature:
Macro PWM_IRQ_EN.
- Defined: extra port irq_o (out, 1). irq_o is a 1-cycle pulse on each period wrap when CTRL.IRQ_EN=1 and EN=1. Reset value 0.
- Undefined: no irq_o port and no IRQ logic. CTRL bit2 is still stored and read back; it has no effect.

Test Plan:
- Sequential write/read: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC -> read back 0x1,0x2,0x3,0x4; all bresp/rresp = 0.
- Byte strobe: write 0xAABBCCDD with wstrb=4'b1111, then 0x11223344 with wstrb=4'b0101 to 0x8 -> read returns 0xAA22CC44.
- Channel skew: wvalid raised 3 cycles after awvalid, and bready held low 5 cycles -> awready/wready pulse together once; bvalid held 5 cycles; no second write occurs.
- PWM timing: PRESCALE=0, PERIOD=9, DUTY=3, CTRL=1 -> pwm_o high 3 cycles, low 7, repeating every 10 cycles. CTRL=3 -> the waveform is inverted.
- Glitch-free update: DUTY changed to 7 mid-period -> current period keeps 3-cycle high; the next period has 7-cycle high. DUTY=0 -> constant low; DUTY=20 -> constant high.
- Reset during write: assert aresetn low while bvalid is pending -> bvalid=0 and pwm_o=0 immediately; all registers read 0 after release. With PWM_IRQ_EN defined and CTRL=5 -> irq_o pulses once per 10-cycle period.
